// File: rtl/ft_pkg.sv
// Shared types and constants for the rollback-recovery controller.
// Build option: define FT_RECOVERY_PC_EN to add the PC checkpoint and JUMP state.
package ft_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CNT_WIDTH  = 8;

`ifdef FT_RECOVERY_PC_EN
  localparam int PC_STAGES = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_RESTORE,
    ST_JUMP,
    ST_RELEASE
  } rec_state_e;
`else
  localparam int PC_STAGES = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_RESTORE,
    ST_RELEASE
  } rec_state_e;
`endif

  // Cycles from the error edge to halt release with the cores already drained:
  // one HALT cycle, every non-zero register, the optional jump, one release.
  function automatic int rec_length(input int addr_width);
    return 1 + (2 ** addr_width - 1) + PC_STAGES + 1;
  endfunction

  localparam int REC_LEN = rec_length(DEF_ADDR_WIDTH);

endpackage

// File: rtl/ft_shadow_rf.sv
// Golden shadow copy of the architectural register file.
// One synchronous write port (cleared by reset) and one combinational read port.
module ft_shadow_rf
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Capture agreed writes; reset clears every entry so a later restore writes zeros.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/ft_recovery_ctrl.sv
// Rollback-recovery controller for the dual-lockstep core pair.
// Halts both cores on a comparator error, rewrites registers 1..N-1 from the
// shadow copy, optionally redirects the PC, then releases the cores.
// Build option: FT_RECOVERY_PC_EN enables the PC checkpoint and the JUMP state.
module ft_recovery_ctrl
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  error_i,
  input  logic                  cmp_we_i,
  input  logic [ADDR_WIDTH-1:0] cmp_addr_i,
  input  logic [DATA_WIDTH-1:0] cmp_data_i,
  input  logic                  commit_valid_i,
  input  logic [DATA_WIDTH-1:0] commit_pc_i,
  input  logic                  halted_i,
  output logic                  halt_o,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_addr_o,
  output logic [DATA_WIDTH-1:0] rf_data_o,
  output logic                  pc_valid_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  rec_count_o
);

  rec_state_e            state_q;
  rec_state_e            state_d;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [CNT_WIDTH-1:0]  rec_count_q;
  logic [DATA_WIDTH-1:0] shadow_rdata;
  logic                  shadow_we;
  logic                  idle;

  assign idle      = (state_q == ST_IDLE);
  assign shadow_we = idle && cmp_we_i && !error_i;

  ft_shadow_rf #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shadow (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (shadow_we),
    .waddr_i(cmp_addr_i),
    .wdata_i(cmp_data_i),
    .raddr_i(idx_q),
    .rdata_o(shadow_rdata)
  );

  // State register, restore index and saturating recovery counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      rec_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (idle && error_i && !(&rec_count_q)) begin
        rec_count_q <= rec_count_q + 1'b1;
      end
      if (state_q == ST_HALT && halted_i) begin
        idx_q <= ADDR_WIDTH'(1);
      end else if (state_q == ST_RESTORE) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

`ifdef FT_RECOVERY_PC_EN
  logic [DATA_WIDTH-1:0] pc_ckpt_q;

  // Remember the PC after the last agreed commit; an erroring cycle is not agreed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_ckpt_q <= '0;
    end else if (idle && commit_valid_i && !error_i) begin
      pc_ckpt_q <= commit_pc_i;
    end
  end
`else
  logic unused_commit;
  assign unused_commit = ^{commit_valid_i, commit_pc_i};
`endif

  // Next-state logic and Moore outputs from the registered state and index.
  always_comb begin
    state_d    = state_q;
    halt_o     = 1'b0;
    rf_we_o    = 1'b0;
    rf_addr_o  = '0;
    rf_data_o  = '0;
    pc_valid_o = 1'b0;
    pc_o       = '0;
    busy_o     = !idle;
    case (state_q)
      ST_IDLE: begin
        if (error_i) state_d = ST_HALT;
      end
      ST_HALT: begin
        halt_o = 1'b1;
        if (halted_i) state_d = ST_RESTORE;
      end
      ST_RESTORE: begin
        halt_o    = 1'b1;
        rf_we_o   = 1'b1;
        rf_addr_o = idx_q;
        rf_data_o = shadow_rdata;
        if (&idx_q) begin
`ifdef FT_RECOVERY_PC_EN
          state_d = ST_JUMP;
`else
          state_d = ST_RELEASE;
`endif
        end
      end
`ifdef FT_RECOVERY_PC_EN
      ST_JUMP: begin
        halt_o     = 1'b1;
        pc_valid_o = 1'b1;
        pc_o       = pc_ckpt_q;
        state_d    = ST_RELEASE;
      end
`endif
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rec_count_o = rec_count_q;

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Self-checking bench for ft_recovery_ctrl: directed table, hand-written
// reset/saturation sequences and randomized traffic against a shadow model.
module tb_ft_recovery_ctrl;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int CW   = 8;
  localparam int NREG = 32;
`ifdef FT_RECOVERY_PC_EN
  localparam int PC_EN = 1;
`else
  localparam int PC_EN = 0;
`endif
  localparam int REC_LEN = 1 + (NREG - 1) + PC_EN + 1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          error_i = 1'b0;
  logic          cmp_we_i = 1'b0;
  logic [AW-1:0] cmp_addr_i = '0;
  logic [DW-1:0] cmp_data_i = '0;
  logic          commit_valid_i = 1'b0;
  logic [DW-1:0] commit_pc_i = '0;
  logic          halted_i = 1'b0;
  logic          halt_o;
  logic          rf_we_o;
  logic [AW-1:0] rf_addr_o;
  logic [DW-1:0] rf_data_o;
  logic          pc_valid_o;
  logic [DW-1:0] pc_o;
  logic          busy_o;
  logic [CW-1:0] rec_count_o;

  ft_recovery_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .error_i       (error_i),
    .cmp_we_i      (cmp_we_i),
    .cmp_addr_i    (cmp_addr_i),
    .cmp_data_i    (cmp_data_i),
    .commit_valid_i(commit_valid_i),
    .commit_pc_i   (commit_pc_i),
    .halted_i      (halted_i),
    .halt_o        (halt_o),
    .rf_we_o       (rf_we_o),
    .rf_addr_o     (rf_addr_o),
    .rf_data_o     (rf_data_o),
    .pc_valid_o    (pc_valid_o),
    .pc_o          (pc_o),
    .busy_o        (busy_o),
    .rec_count_o   (rec_count_o)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  logic [DW-1:0] m_shadow [NREG];
  logic [DW-1:0] m_pc;
  int            m_recs;
  int            tests = 0;
  int            failures = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          cv;
    logic [DW-1:0] pc;
    logic          err;
    int            hdelay;
    int            exp_count;
  } vec_t;

  vec_t vecs [9];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int expCount();
    return (m_recs > 255) ? 255 : m_recs;
  endfunction

  task automatic modelReset();
    foreach (m_shadow[i]) m_shadow[i] = '0;
    m_pc   = '0;
    m_recs = 0;
  endtask

  task automatic driveIdle();
    error_i        = 1'b0;
    cmp_we_i       = 1'b0;
    cmp_addr_i     = '0;
    cmp_data_i     = '0;
    commit_valid_i = 1'b0;
    commit_pc_i    = '0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " halt_o"}, halt_o, 0);
    checkOutput({tag, " rf_we_o"}, rf_we_o, 0);
    checkOutput({tag, " rf_addr/data"}, {rf_addr_o, rf_data_o}, 0);
    checkOutput({tag, " pc_valid/pc"}, {pc_valid_o, pc_o}, 0);
    checkOutput({tag, " busy_o"}, busy_o, 0);
    checkOutput({tag, " rec_count_o"}, rec_count_o, 0);
  endtask

  // One error-free cycle in IDLE; the model takes agreed writes and commits.
  task automatic applyStimulus(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input logic cv, input logic [DW-1:0] pc);
    error_i        = 1'b0;
    cmp_we_i       = we;
    cmp_addr_i     = addr;
    cmp_data_i     = data;
    commit_valid_i = cv;
    commit_pc_i    = pc;
    @(posedge clk_i); #1;
    if (we) m_shadow[addr] = data;
    if (cv) m_pc = pc;
    driveIdle();
    checkOutput("idle busy_o", busy_o, 0);
    checkOutput("idle halt_o", halt_o, 0);
  endtask

  // Raise an error in IDLE (with optional same-cycle write/commit that must be
  // dropped) and follow the whole recovery, checking every restore write.
  task automatic triggerError(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                              input logic cv, input logic [DW-1:0] pc, input int hdelay, input bit noise);
    int  k;
    int  busyCnt;
    int  haltCnt;
    int  nWrites;
    int  firstWr;
    int  pcPulses;
    bit  done;
    error_i        = 1'b1;
    cmp_we_i       = we;
    cmp_addr_i     = addr;
    cmp_data_i     = data;
    commit_valid_i = cv;
    commit_pc_i    = pc;
    halted_i       = (hdelay == 0);
    m_recs++;
    @(posedge clk_i); #1;
    driveIdle();
    checkOutput("halt_o after error", halt_o, 1);
    checkOutput("rec_count_o after error", rec_count_o, expCount());
    k = 1; busyCnt = 0; haltCnt = 0; nWrites = 0; firstWr = 0; pcPulses = 0; done = 0;
    while (k <= 200 + hdelay) begin
      if (!busy_o) begin
        done = 1;
        break;
      end
      busyCnt++;
      if (halt_o) haltCnt++;
      if (rf_we_o) begin
        if (nWrites == 0) firstWr = k;
        if (nWrites < NREG - 1) begin
          checkOutput("restore addr", rf_addr_o, nWrites + 1);
          checkOutput("restore data", rf_data_o, m_shadow[nWrites+1]);
        end
        nWrites++;
      end else begin
        checkOutput("addr/data without strobe", {rf_addr_o, rf_data_o}, 0);
      end
      if (pc_valid_o) begin
        pcPulses++;
        checkOutput("pc target", pc_o, m_pc);
        checkOutput("pc pulse after last write", nWrites, NREG - 1);
      end else begin
        checkOutput("pc_o without strobe", pc_o, 0);
      end
      halted_i = (k > hdelay);
      if (noise) begin
        error_i        = 1'($urandom_range(0, 1));
        cmp_we_i       = 1'($urandom_range(0, 1));
        cmp_addr_i     = AW'($urandom);
        cmp_data_i     = $urandom;
        commit_valid_i = 1'($urandom_range(0, 1));
        commit_pc_i    = $urandom;
      end
      @(posedge clk_i); #1;
      k++;
    end
    driveIdle();
    halted_i = 1'b0;
    checkOutput("recovery finished", done, 1);
    checkOutput("busy cycles", busyCnt, REC_LEN + hdelay);
    checkOutput("halt cycles", haltCnt, REC_LEN - 1 + hdelay);
    checkOutput("restore writes", nWrites, NREG - 1);
    checkOutput("restore start cycle", firstWr, hdelay + 2);
    checkOutput("pc pulses", pcPulses, PC_EN);
    checkOutput("rec_count_o after recovery", rec_count_o, expCount());
  endtask

  initial begin
    int  n;
    bit  found;

    modelReset();
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 32'h0,   1'b0, 0,  0};
    vecs[1] = '{1'b1, 5'd31, 32'h00001234, 1'b1, 32'h80,  1'b0, 0,  0};
    vecs[2] = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,   1'b1, 0,  1};
    vecs[3] = '{1'b1, 5'd7,  32'h0000FFFF, 1'b0, 32'h0,   1'b1, 0,  2};
    vecs[4] = '{1'b1, 5'd7,  32'h00000055, 1'b0, 32'h0,   1'b0, 0,  2};
    vecs[5] = '{1'b1, 5'd7,  32'h00000066, 1'b0, 32'h0,   1'b0, 0,  2};
    vecs[6] = '{1'b1, 5'd0,  32'h0000AAAA, 1'b0, 32'h0,   1'b0, 0,  2};
    vecs[7] = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,   1'b1, 10, 3};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        1'b1, 32'h100, 1'b1, 0,  4};

    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    checkAllZero("reset");
    rst_i = 1'b0;

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].err)
        triggerError(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].cv, vecs[i].pc, vecs[i].hdelay, 1'b0);
      else
        applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].cv, vecs[i].pc);
      checkOutput($sformatf("vec%0d rec_count_o", i), rec_count_o, vecs[i].exp_count);
    end

    // Reset in the middle of a restore abandons it and clears the shadow.
    applyStimulus(1'b1, 5'd20, 32'hCAFEF00D, 1'b1, 32'h44);
    error_i  = 1'b1;
    halted_i = 1'b1;
    @(posedge clk_i); #1;
    driveIdle();
    found = 0;
    for (int c = 0; c < 60; c++) begin
      if (rf_we_o && rf_addr_o == 5'd12) begin
        found = 1;
        break;
      end
      @(posedge clk_i); #1;
    end
    checkOutput("reached x12 restore", found, 1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i    = 1'b0;
    halted_i = 1'b0;
    checkAllZero("mid-restore reset");
    modelReset();
    triggerError(1'b0, '0, '0, 1'b0, '0, 0, 1'b0);

    // Randomized agreed traffic and errors, with noise during recovery.
    for (int r = 0; r < 30; r++) begin
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++)
        applyStimulus(1'($urandom_range(0, 1)), AW'($urandom), $urandom, 1'($urandom_range(0, 1)), $urandom);
      triggerError(1'($urandom_range(0, 1)), AW'($urandom), $urandom, 1'($urandom_range(0, 1)), $urandom,
                   $urandom_range(0, 3), 1'b1);
    end

    // Counter saturation; noise keeps injecting errors outside IDLE.
    for (int s = 0; s < 300; s++)
      triggerError(1'b0, '0, '0, 1'b0, '0, 0, 1'(s % 2));
    checkOutput("rec_count_o saturated", rec_count_o, 255);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
